// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin arbiter feeding one byte at a time into a shared UART transmitter
module uart_tx_sched #(
  parameter int NUM_REQ   = 4,
  parameter int TIMEOUT_W = 16,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 sched_en,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  input  logic                 err_clr,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 ctrl_start_tx,
  input  logic                 stt_tx_done,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 err_timeout,
  output logic [15:0]          tx_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_GAP
  } state_t;

  state_t               state;
  state_t               state_d;
  logic [ID_W-1:0]      last_grant;
  logic [TIMEOUT_W-1:0] timer;
  logic [ID_W-1:0]      sel;
  logic                 found;
  logic [7:0]           sel_data;
  logic                 grant;
  logic                 tmo_hit;
  logic                 set_err;

  // Two passes: requesters above last_grant first, then wrap around from 0.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (ID_W'(i) > last_grant)) begin
        sel   = ID_W'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i]) begin
        sel   = ID_W'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == ID_W'(i)) sel_data = req_data[8*i +: 8];
    end
  end

  // resetn gates the grant so ready cannot pulse while reset is held.
  assign grant = resetn && (state == ST_IDLE) && sched_en && found;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant && (sel == ID_W'(i))) req_ready[i] = 1'b1;
    end
  end

  assign ctrl_start_tx = (state == ST_START);
  assign tmo_hit = (timeout_cycles != '0) && (timer == timeout_cycles - 1'b1);
  assign set_err = (state == ST_WAIT) && !stt_tx_done && tmo_hit;

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:  if (grant) state_d = ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT:  if (stt_tx_done || tmo_hit) state_d = ST_GAP;
      ST_GAP:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      tx_data     <= '0;
      grant_id    <= '0;
      last_grant  <= ID_W'(NUM_REQ - 1);
      timer       <= '0;
      tx_count    <= '0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_d;
      busy  <= (state_d != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (grant) begin
            tx_data    <= sel_data;
            grant_id   <= sel;
            last_grant <= sel;
          end
        end
        ST_START: timer <= '0;
        ST_WAIT: begin
          if (stt_tx_done) begin
            tx_count <= tx_count + 16'd1;
          end else if (!tmo_hit && (timer != '1)) begin
            timer <= timer + 1'b1;
          end
        end
        default: ;
      endcase
      // A timeout in the same cycle as err_clr keeps the flag set.
      if (set_err) begin
        err_timeout <= 1'b1;
      end else if (err_clr) begin
        err_timeout <= 1'b0;
      end
    end
  end

endmodule
